pipe_hazard_ctrl: RTL and testbench

//  Parametrised pipeline control unit for the CPU core. Boot/halt FSM started by the board

---
 rtl/pipe_hazard_ctrl.sv | 118 +++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline control: boot/halt FSM, stall/flush/bubble merge across stages and a
// sticky watchdog on long consecutive stall runs.
module pipe_hazard_ctrl #(
    parameter int NSTAGE   = 5,
    parameter int WDOG_W   = 16,
    parameter int WDOG_MAX = 50000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enter_i,
    input  logic              halt_req_i,
    input  logic [NSTAGE-1:0] stall_req_i,
    input  logic [NSTAGE-1:0] flush_req_i,
    output logic [NSTAGE-1:0] stall_o,
    output logic [NSTAGE-1:0] flush_o,
    output logic [NSTAGE-1:0] bubble_o,
    output logic              inited_o,
    output logic              halted_o,
    output logic              stall_timeout_o
);

    typedef enum logic [1:0] {S_BOOT, S_RUN, S_HALT} state_e;

    localparam logic [WDOG_W-1:0] WMAX = WDOG_W'(WDOG_MAX);

    state_e            state_q;
    logic              e1_q, e2_q;
    logic              inited_q, halted_q, timeout_q, timeout_d;
    logic [WDOG_W-1:0] wdog_q, wdog_d;
    logic              rise;

    logic [NSTAGE-1:0] stall_v, flush_v, bubble_v;
    logic              sseen, fseen;

    assign rise = e1_q & ~e2_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_BOOT;
            e1_q      <= 1'b0;
            e2_q      <= 1'b0;
            inited_q  <= 1'b0;
            halted_q  <= 1'b0;
            timeout_q <= 1'b0;
            wdog_q    <= '0;
        end else begin
            e1_q      <= enter_i;
            e2_q      <= e1_q;
            timeout_q <= timeout_d;
            wdog_q    <= wdog_d;
            case (state_q)
                S_BOOT: if (rise) begin
                    state_q  <= S_RUN;
                    inited_q <= 1'b1;
                end
                // halt_req has priority; a rise in RUN is simply ignored
                S_RUN: if (halt_req_i) begin
                    state_q  <= S_HALT;
                    halted_q <= 1'b1;
                end
                S_HALT: if (rise) begin
                    state_q  <= S_RUN;
                    halted_q <= 1'b0;
                end
                default: state_q <= S_BOOT;
            endcase
        end
    end

    always_comb begin
        wdog_d    = wdog_q;
        timeout_d = timeout_q;
        if (state_q == S_RUN) begin
            if (|stall_req_i) begin
                if (wdog_q != WMAX) wdog_d = wdog_q + 1'b1;
            end else begin
                wdog_d = '0;
            end
        end
        if (wdog_d == WMAX) timeout_d = 1'b1;
    end

    // Scan from the oldest stage down: a stall propagates to every younger stage,
    // and a flush kills everything younger than an unstalled requester.
    always_comb begin
        stall_v  = '0;
        flush_v  = '0;
        bubble_v = '0;
        sseen    = 1'b0;
        fseen    = 1'b0;
        for (int i = NSTAGE - 1; i >= 0; i--) begin
            sseen      = sseen | stall_req_i[i];
            stall_v[i] = sseen;
        end
        for (int i = 1; i < NSTAGE; i++) bubble_v[i] = stall_v[i-1] & ~stall_v[i];
        for (int i = NSTAGE - 1; i >= 0; i--) begin
            flush_v[i] = fseen;
            fseen      = fseen | (flush_req_i[i] & ~stall_v[i]);
        end
    end

    always_comb begin
        if (state_q == S_RUN) begin
            stall_o  = stall_v & ~flush_v;
            flush_o  = flush_v;
            bubble_o = bubble_v;
        end else begin
            stall_o  = '1;
            flush_o  = '0;
            bubble_o = '0;
        end
    end

    assign inited_o        = inited_q;
    assign halted_o        = halted_q;
    assign stall_timeout_o = timeout_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: a behavioural model queues the expected
// outputs for each driven cycle; a monitor pops and compares them mid-cycle.
module tb_pipe_hazard_ctrl;
    localparam int N  = 5;
    localparam int WM = 8;

    logic         clk = 1'b0, rst = 1'b1, enter = 1'b0, halt_req = 1'b0;
    logic [N-1:0] sreq = '0, freq = '0;
    logic [N-1:0] stall_o, flush_o, bubble_o;
    logic         inited_o, halted_o, to_o;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.NSTAGE(N), .WDOG_W(16), .WDOG_MAX(WM)) dut (
        .clk(clk), .rst(rst), .enter_i(enter), .halt_req_i(halt_req),
        .stall_req_i(sreq), .flush_req_i(freq),
        .stall_o(stall_o), .flush_o(flush_o), .bubble_o(bubble_o),
        .inited_o(inited_o), .halted_o(halted_o), .stall_timeout_o(to_o)
    );

    typedef struct packed {
        logic [N-1:0] st, fl, bu;
        logic         ini, hal, to;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0, n_err = 0;

    // model state: 0 BOOT, 1 RUN, 2 HALT
    int   m_st = 0, m_cnt = 0;
    logic m_e1 = 0, m_e2 = 0, m_ini = 0, m_hal = 0, m_to = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic drive(input logic r, input logic en, input logic hr,
                         input logic [N-1:0] sr, input logic [N-1:0] fr);
        exp_t         e;
        int           h, f, st_old;
        logic [N-1:0] s;
        logic         rs;
        @(negedge clk);
        rst = r; enter = en; halt_req = hr; sreq = sr; freq = fr;
        e.ini = m_ini; e.hal = m_hal; e.to = m_to;
        if (m_st == 1) begin
            h = -1;
            for (int i = 0; i < N; i++) if (sr[i]) h = i;
            s    = (h < 0) ? '0 : N'((1 << (h + 1)) - 1);
            e.bu = (h >= 0 && h < N - 1) ? N'(1 << (h + 1)) : '0;
            f = 0;
            for (int k = 1; k < N; k++) if (fr[k] && !s[k]) f = k;
            e.fl = N'((1 << f) - 1);
            e.st = s & ~e.fl;
        end else begin
            e.st = '1; e.fl = '0; e.bu = '0;
        end
        sb.push_back(e);
        if (r) begin
            m_st = 0; m_cnt = 0; m_e1 = 0; m_e2 = 0; m_ini = 0; m_hal = 0; m_to = 0;
        end else begin
            rs = m_e1 & ~m_e2;
            m_e2 = m_e1; m_e1 = en;
            st_old = m_st;
            if (st_old == 1) begin
                if (|sr) begin
                    if (m_cnt < WM) m_cnt++;
                    if (m_cnt == WM) m_to = 1;
                end else m_cnt = 0;
            end
            case (st_old)
                0: if (rs) begin m_st = 1; m_ini = 1; end
                1: if (hr) begin m_st = 2; m_hal = 1; end
                2: if (rs) begin m_st = 1; m_hal = 0; end
                default: m_st = 0;
            endcase
        end
    endtask

    task automatic idle(input int n, input logic en);
        for (int i = 0; i < n; i++) drive(1'b0, en, 1'b0, '0, '0);
    endtask

    task automatic rnd(input int n, input bit allow_rst);
        logic [N-1:0] sr, fr;
        for (int i = 0; i < n; i++) begin
            sr = ($urandom_range(0, 2) == 0) ? N'($urandom) : '0;
            fr = ($urandom_range(0, 1) == 0) ? N'($urandom) : '0;
            drive(allow_rst && ($urandom_range(0, 40) == 0), $urandom_range(0, 3) == 0,
                  $urandom_range(0, 9) == 0, sr, fr);
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #3;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("stall", 32'(stall_o), 32'(e.st));
                chk("flush", 32'(flush_o), 32'(e.fl));
                chk("bubble", 32'(bubble_o), 32'(e.bu));
                chk("inited", 32'(inited_o), 32'(e.ini));
                chk("halted", 32'(halted_o), 32'(e.hal));
                chk("stall_timeout", 32'(to_o), 32'(e.to));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

    initial begin
        // reset, then BOOT idles with requests ignored
        drive(1'b1, 1'b0, 1'b0, '0, '0);
        drive(1'b1, 1'b0, 1'b0, '0, '0);
        for (int i = 0; i < 100; i++) drive(1'b0, 1'b0, i[0], N'($urandom), N'($urandom));
        idle(4, 1'b1);
        // stall merge
        drive(1'b0, 1'b1, 1'b0, 5'b00100, '0);
        drive(1'b0, 1'b1, 1'b0, 5'b10000, '0);
        drive(1'b0, 1'b1, 1'b0, 5'b00001, '0);
        // flush merge, flush ignored at a stalled stage
        drive(1'b0, 1'b1, 1'b0, '0, 5'b00100);
        drive(1'b0, 1'b1, 1'b0, 5'b01000, 5'b00100);
        drive(1'b0, 1'b1, 1'b0, 5'b00001, 5'b10000);
        drive(1'b0, 1'b1, 1'b0, '0, 5'b00001);
        drive(1'b0, 1'b1, 1'b0, 5'b00010, 5'b01001);
        // watchdog: 7 cycles stays clear, 8 cycles sets and sticks
        idle(1, 1'b0);
        for (int i = 0; i < 7; i++) drive(1'b0, 1'b0, 1'b0, 5'b00001, '0);
        idle(2, 1'b0);
        for (int i = 0; i < 8; i++) drive(1'b0, 1'b0, 1'b0, 5'b00010, '0);
        idle(3, 1'b0);
        // halt, resume, then halt_req coinciding with a rise
        drive(1'b0, 1'b0, 1'b1, '0, '0);
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 1'b1, 5'b00100, 5'b10000);
        idle(3, 1'b1);
        drive(1'b0, 1'b0, 1'b0, 5'b00100, '0);
        idle(2, 1'b0);
        drive(1'b0, 1'b1, 1'b0, '0, '0);
        drive(1'b0, 1'b1, 1'b1, '0, '0);
        idle(2, 1'b0);
        idle(3, 1'b1);
        // mid-run reset with stalls and flushes active
        drive(1'b0, 1'b0, 1'b0, 5'b00010, 5'b10000);
        drive(1'b1, 1'b0, 1'b0, 5'b00010, 5'b10000);
        drive(1'b0, 1'b0, 1'b0, 5'b00010, 5'b10000);
        idle(3, 1'b1);
        rnd(300, 1'b1);
        idle(2, 1'b0);
        @(negedge clk);
        #5;
        chk("sb_drain", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
